// File: rtl/part_74s153_scan.sv
// Scan controller for a dual 4-to-1 selector: steps SEL through all four codes,
// samples both group outputs after a settle delay and presents two 4-bit words.
module part_74s153_scan #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ack,
  input  logic       g1q,
  input  logic       g2q,
  output logic       sel0,
  output logic       sel1,
  output logic       enb1_n,
  output logic       enb2_n,
  output logic [3:0] g1d,
  output logic [3:0] g2d,
  output logic       busy,
  output logic       valid,
  output logic [1:0] dbg_state
);

  // Handshake: valid rises when a scan completes and holds g1d/g2d steady;
  // the word is consumed at the first clock edge where valid && ack. A start
  // on that same edge launches the next scan with no idle cycle.

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] sel;
  logic [3:0] cnt;
  logic [2:0] sh1;
  logic [2:0] sh2;

  assign sel0      = sel[0];
  assign sel1      = sel[1];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      sel    <= 2'd0;
      cnt    <= 4'd0;
      sh1    <= 3'd0;
      sh2    <= 3'd0;
      enb1_n <= 1'b1;
      enb2_n <= 1'b1;
      g1d    <= 4'd0;
      g2d    <= 4'd0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            sel    <= 2'd0;
            cnt    <= 4'd0;
            enb1_n <= 1'b0;
            enb2_n <= 1'b0;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt < SETTLE_C) begin
            cnt <= cnt + 4'd1;
          end else begin
            cnt <= 4'd0;
            sel <= sel + 2'd1;
            case (sel)
              2'd0: begin sh1[0] <= g1q; sh2[0] <= g2q; end
              2'd1: begin sh1[1] <= g1q; sh2[1] <= g2q; end
              2'd2: begin sh1[2] <= g1q; sh2[2] <= g2q; end
              default: begin
                // Last code: publish the whole word at once so no partial
                // result is ever visible on g1d/g2d.
                g1d    <= {g1q, sh1};
                g2d    <= {g2q, sh2};
                valid  <= 1'b1;
                busy   <= 1'b0;
                enb1_n <= 1'b1;
                enb2_n <= 1'b1;
                state  <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          if (ack) begin
            valid <= 1'b0;
            if (start) begin
              state  <= SCAN;
              sel    <= 2'd0;
              cnt    <= 4'd0;
              enb1_n <= 1'b0;
              enb2_n <= 1'b0;
              busy   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_part_74s153_scan.sv
// Bench for part_74s153_scan: two instances (SETTLE=2 and SETTLE=0) each driving
// a behavioural selector with selectable output latency.
module tb_part_74s153_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, ack;
  logic [3:0] src1, src2;
  int         lat;

  logic       a_g1q, a_g2q, a_sel0, a_sel1, a_enb1_n, a_enb2_n, a_busy, a_valid;
  logic [3:0] a_g1d, a_g2d;
  logic [1:0] a_state;
  logic       b_g1q, b_g2q, b_sel0, b_sel1, b_enb1_n, b_enb2_n, b_busy, b_valid;
  logic [3:0] b_g1d, b_g2d;
  logic [1:0] b_state;

  part_74s153_scan #(.SETTLE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .g1q(a_g1q), .g2q(a_g2q), .sel0(a_sel0), .sel1(a_sel1),
    .enb1_n(a_enb1_n), .enb2_n(a_enb2_n), .g1d(a_g1d), .g2d(a_g2d),
    .busy(a_busy), .valid(a_valid), .dbg_state(a_state)
  );

  part_74s153_scan #(.SETTLE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .g1q(b_g1q), .g2q(b_g2q), .sel0(b_sel0), .sel1(b_sel1),
    .enb1_n(b_enb1_n), .enb2_n(b_enb2_n), .g1d(b_g1d), .g2d(b_g2d),
    .busy(b_busy), .valid(b_valid), .dbg_state(b_state)
  );

  // Behavioural 74S153: output forced low while its strobe is high.
  function automatic logic mux(input logic [3:0] s, input logic [1:0] sel, input logic en_n);
    return en_n ? 1'b0 : s[sel];
  endfunction

  logic [1:0] a_raw, a_p1, a_p2, b_raw, b_p1, b_p2, a_out, b_out;
  assign a_raw = {mux(src2, {a_sel1, a_sel0}, a_enb2_n), mux(src1, {a_sel1, a_sel0}, a_enb1_n)};
  assign b_raw = {mux(src2, {b_sel1, b_sel0}, b_enb2_n), mux(src1, {b_sel1, b_sel0}, b_enb1_n)};
  always @(posedge clk) begin
    a_p1 <= a_raw; a_p2 <= a_p1;
    b_p1 <= b_raw; b_p2 <= b_p1;
  end
  assign a_out = (lat == 0) ? a_raw : (lat == 1) ? a_p1 : a_p2;
  assign b_out = (lat == 0) ? b_raw : (lat == 1) ? b_p1 : b_p2;
  assign a_g1q = a_out[0];
  assign a_g2q = a_out[1];
  assign b_g1q = b_out[0];
  assign b_g2q = b_out[1];

  // Reference: bit i is sampled (i+1)*(settle+1) edges after start; a selector
  // with latency l then shows the code that was driven l edges earlier. Before
  // the start edge the selector is disabled (reads 0) for at least l cycles.
  function automatic logic [3:0] model_word(input logic [3:0] src, input int settle, input int l);
    logic [3:0] w;
    int c, k;
    for (int i = 0; i < 4; i++) begin
      c = (i + 1) * (settle + 1);
      k = c - l;
      w[i] = (k <= 0) ? 1'b0 : src[(k - 1) / (settle + 1)];
    end
    return w;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Called at a negedge. Returns edges from start to a_valid, first b_valid
  // edge, and count of cycles where dut_a's SEL/BUSY/ENB stepping was wrong.
  task automatic run_scan(input logic with_ack, input int pulse_at,
                          output int a_n, output int b_n, output int seq_err);
    start = 1'b1;
    ack   = with_ack;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    a_n = 0; b_n = -1; seq_err = 0;
    while (!a_valid && a_n < 64) begin
      if ({a_sel1, a_sel0} != 2'(a_n / 3) || !a_busy || a_enb1_n || a_enb2_n) seq_err++;
      start = (a_n == pulse_at);
      @(negedge clk);
      a_n++;
      if (b_valid && b_n < 0) b_n = a_n;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0] s1, s2;
    int         l;
    logic [3:0] a1, a2, b1, b2;
  } vec_t;

  vec_t tbl[3];
  int   an, bn, se, cnt;
  logic [3:0] w1, w2;

  initial begin
    tbl[0] = '{4'b1010, 4'b0110, 0, 4'b1010, 4'b0110, 4'b1010, 4'b0110};
    tbl[1] = '{4'b1001, 4'b0101, 2, 4'b1001, 4'b0101, 4'b0100, 4'b0100};
    tbl[2] = '{4'b1111, 4'b0000, 1, 4'b1111, 4'b0000, 4'b1110, 4'b0000};

    src1 = 4'd0; src2 = 4'd0; lat = 0;
    reset_n = 1'b0; start = 1'b1; ack = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_a", {a_sel1, a_sel0, a_enb1_n, a_enb2_n, a_busy, a_valid, a_g1d, a_g2d, a_state},
          {2'b00, 2'b11, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0});
    check("reset_b", {b_sel1, b_sel0, b_enb1_n, b_enb2_n, b_busy, b_valid, b_g1d, b_g2d},
          {2'b00, 2'b11, 1'b0, 1'b0, 4'h0, 4'h0});
    reset_n = 1'b1; start = 1'b0; ack = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      src1 = tbl[v].s1; src2 = tbl[v].s2; lat = tbl[v].l;
      repeat (2) @(negedge clk);
      run_scan(1'b0, -1, an, bn, se);
      check($sformatf("latency_a[%0d]", v), an, 12);
      check($sformatf("latency_b[%0d]", v), bn, 4);
      check($sformatf("sel_seq[%0d]", v), se, 0);
      check($sformatf("word_a[%0d]", v), {a_g1d, a_g2d}, {tbl[v].a1, tbl[v].a2});
      check($sformatf("word_b[%0d]", v), {b_g1d, b_g2d}, {tbl[v].b1, tbl[v].b2});
      check($sformatf("done_a[%0d]", v), {a_sel1, a_sel0, a_enb1_n, a_enb2_n, a_busy, a_state},
            {2'b00, 2'b11, 1'b0, 2'd2});
      do_ack();
      check($sformatf("acked[%0d]", v), {a_valid, b_valid, a_busy, a_g1d, a_g2d},
            {3'b000, tbl[v].a1, tbl[v].a2});
    end

    for (int r = 0; r < 8; r++) begin
      src1 = 4'($urandom_range(0, 15)); src2 = 4'($urandom_range(0, 15));
      lat = $urandom_range(0, 2);
      repeat (2) @(negedge clk);
      run_scan(1'b0, -1, an, bn, se);
      check($sformatf("rand_a[%0d]", r), {a_g1d, a_g2d},
            {model_word(src1, 2, lat), model_word(src2, 2, lat)});
      check($sformatf("rand_b[%0d]", r), {b_g1d, b_g2d},
            {model_word(src1, 0, lat), model_word(src2, 0, lat)});
      do_ack();
    end

    // Back-to-back: new sources applied while DONE, then ACK+START together.
    src1 = 4'b1010; src2 = 4'b0110; lat = 0;
    repeat (2) @(negedge clk);
    run_scan(1'b0, -1, an, bn, se);
    src1 = 4'b1111; src2 = 4'b0000;
    @(negedge clk);
    run_scan(1'b1, -1, an, bn, se);
    check("b2b_latency", an, 12);
    check("b2b_seq", se, 0);
    check("b2b_word_a", {a_g1d, a_g2d}, {4'b1111, 4'b0000});
    check("b2b_word_b", {b_g1d, b_g2d}, {model_word(src1, 0, 0), model_word(src2, 0, 0)});
    do_ack();

    // START mid-scan and START without ACK in DONE are both ignored.
    src1 = 4'b0011; src2 = 4'b1100; lat = 2;
    repeat (2) @(negedge clk);
    run_scan(1'b0, 5, an, bn, se);
    check("ign_latency", an, 12);
    check("ign_word", {a_g1d, a_g2d}, {4'b0011, 4'b1100});
    cnt = 0;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!a_valid || a_busy || a_g1d != 4'b0011) cnt++;
    end
    start = 1'b0;
    check("ign_done_hold", cnt, 0);
    do_ack();
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_valid || a_busy) cnt++;
    end
    check("ign_no_extra_scan", cnt, 0);

    // Reset asserted on the SEL=10 capture edge (ninth edge after start).
    src1 = 4'b0110; src2 = 4'b1001; lat = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_sel", {a_sel1, a_sel0, a_busy}, {2'b10, 1'b1});
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_reset", {a_sel1, a_sel0, a_enb1_n, a_enb2_n, a_busy, a_valid, a_g1d, a_g2d, a_state},
          {2'b00, 2'b11, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0});
    repeat (2) @(negedge clk);
    run_scan(1'b0, -1, an, bn, se);
    check("post_reset_word", {a_g1d, a_g2d}, {4'b0110, 4'b1001});
    check("post_reset_latency", an, 12);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/part_74s153_scan.md
Name: part_74S153_scan

Overview:
- Receive-side companion for a dual 4-to-1 selector (74S153-style part) in the CADR datapath.
- The selector serialises four sources per group onto G1Q/G2Q. This block drives SEL1:SEL0 and the group enables through all four codes, waits a programmable settle time at each code, then samples.
- The samples are reassembled into two 4-bit parallel words, which are presented with a VALID/ACK handshake.

Parameters:
- SETTLE, 2, number of extra cycles each select code is held before sampling. Legal range 0..15; each code is held SETTLE+1 cycles.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- START  input  1  request one scan. Sampled only in IDLE, or in DONE together with ACK.
- ACK  input  1  consumer has taken G1D/G2D. Meaningful only while VALID=1.
- G1Q  input  1  group-1 selector output.
- G2Q  input  1  group-2 selector output.
- SEL0  output  1  select LSB driven to the selector.
- SEL1  output  1  select MSB driven to the selector.
- ENB1_N  output  1  group-1 enable, active low.
- ENB2_N  output  1  group-2 enable, active low.
- G1D  output  4  group-1 word; bit i is G1Q sampled with SEL=i.
- G2D  output  4  group-2 word; bit i is G2Q sampled with SEL=i.
- BUSY  output  1  high while a scan is in progress.
- VALID  output  1  G1D/G2D hold a fresh, unacknowledged word.

Behaviour:
- Reset (RESET_N=0 at an edge) sets, at that edge: state IDLE, SEL1:SEL0=00, ENB1_N=ENB2_N=1, G1D=G2D=0000, BUSY=0, VALID=0, settle counter=0, shadow bits=0.
  - Reset has priority over every other input.
  - Reset mid-scan aborts the scan with no partial update.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - START=1 at edge E0 -> SCAN. After E0: SEL=00, ENB1_N=ENB2_N=0, BUSY=1, counter=0.
  - START=0 -> stay in IDLE.
- SCAN, at each edge:
  - If counter<SETTLE: counter+1, SEL unchanged.
  - If counter==SETTLE: G1Q/G2Q are captured into bit SEL of the group-1/group-2 shadow, counter=0, SEL+1.
  - Capture at SEL=11, same edge:
    - G1D/G2D load {G1Q, shadow[2:0]} / {G2Q, shadow[2:0]} for their group.
    - VALID=1, BUSY=0, SEL wraps to 00, ENB1_N=ENB2_N=1.
    - State -> DONE.
  - START is ignored in SCAN. ACK is ignored in SCAN.
- Latency: capture of bit i occurs at edge E0+(i+1)*(SETTLE+1). VALID rises after edge E0+4*(SETTLE+1), i.e. after E12 with SETTLE=2, after E4 with SETTLE=0.
- DONE:
  - G1D/G2D are stable and VALID=1 until ACK=1 at an edge.
  - ACK=1, START=0 -> VALID=0, IDLE.
  - ACK=1, START=1 -> VALID=0, directly to SCAN as from IDLE (back-to-back; no idle cycle).
  - START=1, ACK=0 -> ignored; no new scan until ACK.
- G1D/G2D change only at scan completion or reset. They keep their value after ACK until the next completion.
- Shadow registers are internal and never visible on G1D/G2D mid-scan.
- Counter width is 4 bits. SEL is a 2-bit wrapping counter.

Test Plan:
- Reset: drive RESET_N=0 for 2 edges with START=1, ACK=1 -> all outputs at reset values (SEL=00, ENB_N=11, G1D=G2D=0, BUSY=0, VALID=0).
- Basic scan, SETTLE=2: behavioural selector with group1 sources=1010b and group2=0110b (C3..C0), START for 1 cycle.
  - SEL steps 00,01,10,11, each held 3 cycles.
  - VALID rises after E12 with G1D=1010, G2D=0110, ENB_N=11.
  - After ACK, VALID=0 and G1D still 1010.
- Settle honoured: selector with 2-cycle output delay, SETTLE=2 vs SETTLE=0, sources 1001/0101 -> SETTLE=2 gives correct words. SETTLE=0 (4-cycle scan) must show stale bits, proving sample timing.
- Back-to-back: in DONE, assert ACK and START together with new sources 1111/0000.
  - Next cycle BUSY=1, SEL=00.
  - VALID rises again 12 edges later with 1111/0000.
- Ignored requests: START pulses mid-SCAN and in DONE without ACK -> exactly one completion, with no extra scan.
- Reset mid-scan: RESET_N=0 at the SEL=10 capture edge -> next cycle IDLE, G1D=G2D=0, VALID=0. A following START yields a complete correct word.
